uart_rx_sipo: RTL
=================

# uart_rx_sipo

Serial-in/parallel-out UART receive stage, the counterpart of our PISO transmitter. It consumes an 11-bit frame from the serial line: start 0, data[7:0] LSB first, parity, stop 1. It samples each bit at mid-bit using an oversampled `baud_clk`, then presents the byte with parity and framing status. It feeds the receive-side register/buffer logic.

## Interface
- `OVERSAMPLE`, 16, `baud_clk` cycles per serial bit; even, ≥4.
- `reset_n`  in  1  reset reset_n, asynchronous, active-low.
- `baud_clk`  in  1  clock baud_clk (OVERSAMPLE × bit rate).
- `data_rx`  in  1  serial line, idle high, asynchronous to `baud_clk`.
- `parity_type`  in  1  0 = even, 1 = odd; must be static during a frame.
- `data_out`  out  8  last received byte; held until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when `data_out` and the error flags update.
- `parity_error`  out  1  parity mismatch on the last frame; updated with `rx_valid`.
- `framing_error`  out  1  stop bit sampled 0 on the last frame; updated with `rx_valid`.
- `active_flag`  out  1  high while a frame is being received (states START through STOP).
- `done_flag`  out  1  equals `!active_flag`.

## Operation
- **Synchronizer:** `data_rx` passes through a 2-flop synchronizer, giving `rx_s`. All logic uses `rx_s` only. Both flops reset to 1.
- **Counters:**
  - `tick_cnt` is $clog2(OVERSAMPLE) bits wide. It resets to 0 on every state change.
  - `bit_idx` is 3 bits wide.
- **Shift register:** `shift_r[7:0]` shifts right, inserting each sampled bit at bit 7. After 8 samples, `shift_r` holds the byte LSB-first.
- **Parity:** expected parity = `^shift_r ^ parity_type`. This equals the transmitter's parity_bit for the even (0) and odd (1) settings.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - **IDLE:** if `rx_s==0` → START.
  - **START:** when `tick_cnt==OVERSAMPLE/2-1`, sample `rx_s`.
    - Sample 1 (glitch) → IDLE; no outputs change.
    - Sample 0 → DATA, with `bit_idx=0`.
  - **DATA:** when `tick_cnt==OVERSAMPLE-1`, sample `rx_s` into `shift_r` and increment `bit_idx`. After the sample taken with `bit_idx==7` → PARITY.
  - **PARITY:** when `tick_cnt==OVERSAMPLE-1`, sample `rx_s` into `par_s` → STOP.
  - **STOP:** when `tick_cnt==OVERSAMPLE-1`, sample `rx_s`. On that edge the block:
    - loads `data_out <= shift_r`;
    - sets `parity_error <= (par_s != expected)`;
    - sets `framing_error <= !rx_s`;
    - sets `rx_valid <= 1`.
    - Next state: stop sample 1 → IDLE; stop sample 0 → WAIT_HIGH.
  - **WAIT_HIGH** (break / line stuck low): stay until `rx_s==1` → IDLE. This state is not counted as active.
- **Output timing:** `rx_valid` is high for exactly one cycle after the STOP sample edge. All other outputs are registered.
- **Mid-frame reset:** asynchronous. The FSM goes to IDLE immediately and the partial frame is discarded with no `rx_valid`.
- **Back-to-back frames:** a start bit that immediately follows a valid stop bit is accepted. IDLE sees `rx_s==0` within one cycle of returning, and the mid-bit margin covers this slip.

## Timing
- **Reset values:** `data_out=8'h00`, `rx_valid=0`, `parity_error=0`, `framing_error=0`, `active_flag=0`, `done_flag=1`, FSM in IDLE.
- **Reference edge:** call E the `baud_clk` edge at which IDLE first sees `rx_s==0`. This is 2–3 cycles after the `data_rx` fall.
- **Sample points** (relative to E):
  - Start sample at E + OVERSAMPLE/2.
  - Data bit k at E + OVERSAMPLE/2 + (k+1)·OVERSAMPLE.
  - Parity at E + OVERSAMPLE/2 + 9·OVERSAMPLE.
  - Stop at E + OVERSAMPLE/2 + 10·OVERSAMPLE.
- **`rx_valid` window:** high during the cycle following the stop sample edge. With OVERSAMPLE=16 this is E+168.
- **`active_flag`:** rises the cycle after E. Falls in the same cycle that `rx_valid` rises, or the cycle after a glitch rejection.
- **Tolerance:** at most ±OVERSAMPLE/2 − 1 cycles of accumulated drift over the frame.

## Test plan
- **Even-parity frame:** OVERSAMPLE=16, `parity_type=0`; send frame 0xA5 with parity 0, stop 1 → `rx_valid` pulses once with `data_out=8'hA5`, `parity_error=0`, `framing_error=0`, at E+168.
- **Odd parity and parity mismatch:** `parity_type=1`; send 0x3C with parity 1 → no error. Resend 0x3C with parity 0 → `data_out=8'h3C`, `parity_error=1`.
- **Framing error and break:** send 0x00 with stop bit 0, then hold the line low for 40 cycles → `framing_error=1`, `rx_valid` pulses once. FSM stays in WAIT_HIGH with `active_flag=0`, and no new frame starts until the line returns high.
- **Start glitch rejection:** drive `data_rx` low for 3 cycles, then high → no `rx_valid`; `active_flag` returns to 0 at E+9; `data_out` unchanged.
- **Mid-frame reset:** assert `reset_n=0` during data bit 4 of frame 0x5A → all outputs return to reset values immediately, and no `rx_valid`. The next full frame, 0x81, is received correctly.
- **Back-to-back frames:** send 0x01, 0xFE, 0x55 with no idle gap between frames → exactly three `rx_valid` pulses, 176 cycles apart, carrying 0x01, 0xFE, 0x55, all with error flags 0.

Source files
------------

// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo - serial-in/parallel-out UART receive stage.
// Receives an 11-bit frame (start 0, data[7:0] LSB first, parity, stop 1)
// sampled at mid-bit from an oversampled baud_clk, and reports the byte
// together with parity and framing status.
//
// Ports:
//   baud_clk      in   clock, OVERSAMPLE x bit rate
//   reset_n       in   asynchronous active-low reset
//   data_rx       in   serial line, idle high, asynchronous to baud_clk
//   parity_type   in   0 = even, 1 = odd (static during a frame)
//   data_out      out  last received byte, held until the next frame completes
//   rx_valid      out  one-cycle pulse when data_out and error flags update
//   parity_error  out  parity mismatch on the last frame
//   framing_error out  stop bit sampled 0 on the last frame
//   active_flag   out  high while a frame is in START..STOP
//   done_flag     out  complement of active_flag
module uart_rx_sipo #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baud_clk,
    input  logic       reset_n,
    input  logic       data_rx,
    input  logic       parity_type,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    // Parity bit the transmitter would have sent for this byte.
    function automatic logic expected_parity(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic          sync1_q, sync2_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          rx_valid_q, rx_valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          active_q, active_d;
    logic          done_q;

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= data_rx;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            data_out_q <= 8'h00;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            data_out_q <= data_out_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            active_q   <= active_d;
            done_q     <= !active_d;
        end
    end

    // Next-state and datapath logic; tick_cnt restarts from 0 on every sample.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q + TW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        data_out_d = data_out_q;
        rx_valid_d = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_q == HALF_M1) begin
                    tick_d = '0;
                    if (rx_s) begin
                        // Start bit did not persist to mid-bit: treat as a glitch.
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_q == FULL_M1) begin
                    tick_d    = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_q == FULL_M1) begin
                    tick_d     = '0;
                    data_out_d = shift_q;
                    perr_d     = (par_q != expected_parity(shift_q, parity_type));
                    ferr_d     = !rx_s;
                    rx_valid_d = 1'b1;
                    // A low stop bit means a break or stuck line: wait for idle.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                tick_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // active_flag is registered from the upcoming state so it rises the cycle
    // after the start edge and falls together with rx_valid.
    always_comb begin
        case (state_d)
            ST_START, ST_DATA, ST_PARITY, ST_STOP: active_d = 1'b1;
            default:                               active_d = 1'b0;
        endcase
    end

    assign data_out      = data_out_q;
    assign rx_valid      = rx_valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign active_flag   = active_q;
    assign done_flag     = done_q;

endmodule
